// File: rtl/lc_1252_odd_count.sv
// Odd-cell counter: keeps row/column parity bitmaps over an index stream,
// then scans them and emits R*(n-C) + (m-R)*C on a valid/ready port.
module lc_1252_odd_count #(
  parameter int MAX_DIM = 50,
  parameter int OUT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       m,
  input  logic [7:0]       n,
  input  logic [1:0][7:0]  ind_tdata,
  input  logic             ind_tvalid,
  input  logic             ind_tlast,
  output logic             ind_tready,
  output logic [OUT_W-1:0] odd_cells,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             err
);

  localparam int KW = $clog2(MAX_DIM);
  localparam logic [MAX_DIM-1:0] ONE = {{(MAX_DIM-1){1'b0}}, 1'b1};
  localparam logic [7:0] DMAX = 8'(MAX_DIM);
  localparam logic [KW-1:0] KLAST = KW'(MAX_DIM - 1);

  typedef enum logic [1:0] {ACCUM, COUNT, CALC, OUT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [MAX_DIM-1:0] r_row_par;
  logic [MAX_DIM-1:0] r_col_par;
  logic [7:0]         r_m;
  logic [7:0]         r_n;
  logic [7:0]         r_r;
  logic [7:0]         r_c;
  logic [KW-1:0]      r_k;
  logic               r_err_acc;
  logic [OUT_W-1:0]   r_odd;
  logic               r_out_valid;
  logic               r_err;

  logic               w_acc;
  logic               w_hs;
  logic [MAX_DIM-1:0] w_row_hot;
  logic [MAX_DIM-1:0] w_col_hot;
  logic               w_row_bad;
  logic               w_col_bad;
  logic               w_dim_bad;
  logic               w_rbit;
  logic               w_cbit;
  logic [OUT_W-1:0]   w_calc;

  assign ind_tready = !rst && (r_state == ACCUM);
  assign out_tvalid = r_out_valid;
  assign odd_cells  = r_odd;
  assign err        = r_err;

  assign w_acc = ind_tvalid && ind_tready;
  assign w_hs  = (r_state == OUT) && r_out_valid && out_tready;

  // out-of-range indices shift the one-hot off the end, so no toggle happens
  assign w_row_hot = ONE << ind_tdata[0];
  assign w_col_hot = ONE << ind_tdata[1];
  assign w_row_bad = ind_tdata[0] >= DMAX;
  assign w_col_bad = ind_tdata[1] >= DMAX;
  assign w_dim_bad = (m == 8'd0) || (n == 8'd0) ||
                     (m > DMAX) || (n > DMAX);

  assign w_rbit = r_row_par[r_k] && (8'(r_k) < r_m);
  assign w_cbit = r_col_par[r_k] && (8'(r_k) < r_n);

  assign w_calc = OUT_W'(r_r) * (OUT_W'(r_n) - OUT_W'(r_c)) +
                  (OUT_W'(r_m) - OUT_W'(r_r)) * OUT_W'(r_c);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACCUM: if (w_acc && ind_tlast) w_state_nxt = COUNT;
      COUNT: if (r_k == KLAST) w_state_nxt = CALC;
      CALC:  w_state_nxt = OUT;
      OUT:   if (w_hs) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_row_par   <= '0;
      r_col_par   <= '0;
      r_m         <= '0;
      r_n         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_k         <= '0;
      r_err_acc   <= 1'b0;
      r_odd       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ACCUM: begin
          if (w_acc) begin
            r_row_par <= r_row_par ^ w_row_hot;
            r_col_par <= r_col_par ^ w_col_hot;
            r_err_acc <= r_err_acc | w_row_bad | w_col_bad |
                         (ind_tlast & w_dim_bad);
            if (ind_tlast) begin
              r_m <= m;
              r_n <= n;
              r_k <= '0;
            end
          end
        end
        COUNT: begin
          r_r <= r_r + 8'(w_rbit);
          r_c <= r_c + 8'(w_cbit);
          r_k <= r_k + KW'(1);
        end
        CALC: begin
          r_odd <= r_err_acc ? '0 : w_calc;
          r_err <= r_err_acc;
        end
        OUT: begin
          // valid is raised one cycle after the result is latched
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_tready) begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_row_par   <= '0;
            r_col_par   <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_err_acc   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc_1252_odd_count.sv
// Directed bench for lc_1252_odd_count: table of problems plus
// backpressure and reset-mid-scan sequences.
module tb_lc_1252_odd_count;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       m;
  logic [7:0]       n;
  logic [1:0][7:0]  ind_tdata;
  logic             ind_tvalid;
  logic             ind_tlast;
  logic             ind_tready;
  logic [15:0]      odd_cells;
  logic             out_tvalid;
  logic             out_tready;
  logic             err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc_1252_odd_count #(.MAX_DIM(50), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .m(m), .n(n),
    .ind_tdata(ind_tdata), .ind_tvalid(ind_tvalid),
    .ind_tlast(ind_tlast), .ind_tready(ind_tready),
    .odd_cells(odd_cells), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .err(err)
  );

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  n;
    int          nb;
    logic [7:0]  r0, c0, r1, c1, r2, c2;
    logic [15:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(input logic [7:0] mm, nn, input int nb,
      input logic [7:0] r0, c0, r1, c1, r2, c2,
      input logic [15:0] e, input logic ee);
    vec_t v;
    v.m = mm; v.n = nn; v.nb = nb;
    v.r0 = r0; v.c0 = c0; v.r1 = r1; v.c1 = c1; v.r2 = r2; v.c2 = c2;
    v.exp = e; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beats(input vec_t v);
    for (int b = 0; b < v.nb; b++) begin
      @(negedge clk);
      ind_tvalid = 1'b1;
      ind_tlast  = (b == v.nb - 1);
      m = v.m;
      n = v.n;
      case (b)
        0: ind_tdata = {v.c0, v.r0};
        1: ind_tdata = {v.c1, v.r1};
        default: ind_tdata = {v.c2, v.r2};
      endcase
      @(posedge clk);
    end
    #1;
    ind_tvalid = 1'b0;
    ind_tlast  = 1'b0;
    m = 8'hxx;
    n = 8'hxx;
  endtask

  task automatic run(input string tag, input vec_t v, input int hold);
    int lat;
    int stable_bad;
    out_tready = (hold == 0);
    send_beats(v);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_tvalid && lat < 200);
    chk({tag, " latency"}, lat, 52);
    chk({tag, " odd_cells"}, odd_cells, v.exp);
    chk({tag, " err"}, err, v.exp_err);
    if (hold > 0) begin
      stable_bad = 0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!out_tvalid || odd_cells != v.exp || ind_tready)
          stable_bad++;
      end
      chk({tag, " held stable"}, stable_bad, 0);
      @(negedge clk);
      out_tready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, " valid drop"}, out_tvalid, 0);
    chk({tag, " ready back"}, ind_tready, 1);
    chk({tag, " err clear"}, err, 0);
  endtask

  initial begin
    int seen;
    vt[0]  = mk(2, 3, 2, 0, 1, 1, 1, 0, 0, 6, 0);
    vt[1]  = mk(2, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(50, 50, 1, 0, 0, 0, 0, 0, 0, 98, 0);
    vt[3]  = mk(2, 2, 2, 60, 0, 1, 1, 0, 0, 0, 1);
    vt[4]  = mk(2, 3, 2, 0, 1, 1, 1, 0, 0, 6, 0);
    vt[5]  = mk(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[6]  = mk(3, 3, 1, 0, 0, 0, 0, 0, 0, 4, 0);
    vt[7]  = mk(2, 2, 1, 5, 0, 0, 0, 0, 0, 2, 0);
    vt[8]  = mk(2, 2, 1, 0, 50, 0, 0, 0, 0, 0, 1);
    vt[9]  = mk(51, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[10] = mk(50, 50, 3, 49, 49, 3, 7, 3, 7, 98, 0);

    rst = 1'b1;
    m = 0; n = 0; ind_tdata = '0;
    ind_tvalid = 0; ind_tlast = 0; out_tready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ind_tready", ind_tready, 0);
    chk("reset out_tvalid", out_tvalid, 0);
    chk("reset odd_cells", odd_cells, 0);
    chk("reset err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset ind_tready", ind_tready, 1);

    for (int i = 0; i < 11; i++)
      run($sformatf("vec%0d", i), vt[i], 0);

    run("backpressure", vt[0], 20);

    // reset ten cycles into the scan must discard the problem
    send_beats(vt[0]);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid-count ind_tready", ind_tready, 1);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_tvalid) seen++;
    end
    chk("mid-count no result", seen, 0);
    run("after reset", vt[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
